// File: rtl/ram_scan_reader.sv
// Scans a 32x4 synchronous RAM, advancing on a periodic tick or a step edge.
// Define RAM_SCAN_STEP_EN to enable the step input; otherwise step is ignored.
module ram_scan_reader #(
    parameter int TICK_DIV = 50000000,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] rd_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              data_valid
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        CAPTURE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             step_edge;
    logic             pending;
    logic             advance;

    assign tick    = run && (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign advance = tick || step_edge || pending;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (!run || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

`ifdef RAM_SCAN_STEP_EN
    logic step_q;

    assign step_edge = step && !step_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`else
    logic unused_step;

    assign unused_step = step;
    assign step_edge   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= INIT;
            rd_address <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            data_valid <= 1'b0;
            pending    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                INIT: begin
                    rd_address <= '0;
                    if (tick) pending <= 1'b1;
                    state <= WAIT;
                end
                IDLE: begin
                    if (advance) begin
                        rd_address <= rd_address + ADDR_W'(1);
                        pending    <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // RAM read latency: rd_q becomes valid during this cycle
                    if (tick) pending <= 1'b1;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (tick) pending <= 1'b1;
                    disp_data  <= rd_q;
                    disp_addr  <= rd_address;
                    data_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Randomized bench for ram_scan_reader against a cycle-count reference model.
// Honours RAM_SCAN_STEP_EN the same way as the design.
module tb_ram_scan_reader;

    localparam int TD = 8;
    localparam int AW = 5;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          run;
    logic          step;
    logic [AW-1:0] rd_address;
    logic [DW-1:0] rd_q;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          data_valid;

    logic [DW-1:0] mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_addr, m_left, m_cnt, m_daddr, m_ddata;
    bit m_pend, m_stepq, m_valid;

    int pulses;

    ram_scan_reader #(.TICK_DIV(TD), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .run        (run),
        .step       (step),
        .rd_address (rd_address),
        .rd_q       (rd_q),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .data_valid (data_valid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_q <= mem[rd_address];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // One rising edge of the reference: left = edges remaining until capture
    task automatic model_edge();
        bit tk, sedge;
        if (!resetn) begin
            m_addr = 0; m_cnt = 0; m_pend = 0; m_stepq = 0;
            m_daddr = 0; m_ddata = 0; m_valid = 0; m_left = 3;
            return;
        end
        tk = run && (m_cnt == TD - 1);
        m_cnt = (run && !tk) ? m_cnt + 1 : 0;
`ifdef RAM_SCAN_STEP_EN
        sedge = step && !m_stepq;
`else
        sedge = 0;
`endif
        m_stepq = step;
        m_valid = 0;
        if (m_left > 0) begin
            if (tk) m_pend = 1;
            m_left--;
            if (m_left == 0) begin
                m_daddr = m_addr;
                m_ddata = mem[m_addr];
                m_valid = 1;
            end
        end else if (tk || sedge || m_pend) begin
            m_addr = (m_addr + 1) % 32;
            m_pend = 0;
            m_left = 2;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        if (data_valid) pulses++;
        check("data_valid", data_valid, m_valid);
        check("rd_address", rd_address, m_addr);
        check("disp_addr", disp_addr, m_daddr);
        check("disp_data", disp_data, m_ddata);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) mem[i] = DW'(i % 16);
        mem[0] = 4'hA;
        resetn = 1'b0; run = 1'b0; step = 1'b0;
        m_left = 3;
        cycle();
        cycle();
        check("reset_dv", data_valid, 0);
        check("reset_addr", rd_address, 0);

        // release, run=0: one capture of address 0 at the third edge
        resetn = 1'b1;
        pulses = 0;
        cycle();
        cycle();
        check("pre_cap_dv", data_valid, 0);
        cycle();
        check("cap0_dv", data_valid, 1);
        check("cap0_addr", disp_addr, 0);
        check("cap0_data", disp_data, 32'hA);
        for (int i = 0; i < 30; i++) cycle();
        check("idle_pulses", pulses, 1);

        // automatic scan through the wrap at 31
        run = 1'b1;
        for (int i = 0; i < 34 * TD; i++) cycle();
        run = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // step held high: at most one advance
        pulses = 0;
        step = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        step = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
`ifdef RAM_SCAN_STEP_EN
        check("step_hold_pulses", pulses, 1);
`else
        for (int i = 0; i < 10; i++) begin
            step = ~step;
            cycle();
        end
        check("step_ignored", pulses, 0);
`endif

        // reset during WAIT at address 7
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 40 * TD && !found; i++) begin
            cycle();
            if (m_addr == 7 && m_left == 2) found = 1;
        end
        check("find_wait7", found, 1);
        resetn = 1'b0;
        cycle();
        check("abort_dv", data_valid, 0);
        check("abort_addr", rd_address, 0);
        resetn = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // randomized mix of run, step, reset and RAM contents
        resetn = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
        cycle();
        resetn = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            resetn = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0) step = ~step;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
